seq_divider: RTL



---
 rtl/seq_divider_pkg.sv | 12 +
 rtl/seq_divider_iter_down_counter.sv | 32 +++
 rtl/seq_divider.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_divider_iter_down_counter.sv
// Iteration down-counter: reset, then clear, then load, then decrement; saturates at zero.
module iter_down_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en_dec,
  output logic             zero,
  output logic [CNT_W-1:0] out
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);
  assign out  = r_cnt;

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN to add the signed_op input (two's-complement division).
module seq_divider import seq_divider_pkg::*; #(
  parameter  int WIDTH = DIV_DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_count
);

  // Handshake: a transfer happens on an edge where valid and ready are both high;
  // src_ready is high only in IDLE, dst_valid only in DONE, and neither depends on the other side.

  div_state_e       r_state;
  logic             r_src_ready;
  logic             r_dst_valid;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_cnt_zero;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign w_dvd_neg = signed_op & dividend[WIDTH-1];
  assign w_dvs_neg = signed_op & divisor[WIDTH-1];
`else
  assign w_dvd_neg = 1'b0;
  assign w_dvs_neg = 1'b0;
`endif

  // MIN negates to itself, which read as unsigned is exactly |MIN|.
  assign w_dvd_mag = w_dvd_neg ? (-dividend) : dividend;
  assign w_dvs_mag = w_dvs_neg ? (-divisor)  : divisor;

  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_rem_next = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_q_fix    = r_neg_q ? (-w_quo_next) : w_quo_next;
  assign w_r_fix    = r_neg_r ? (-w_rem_next) : w_rem_next;

  assign w_cnt_load = (r_state == IDLE) && src_valid;
  assign w_cnt_dec  = (r_state == CALC);

  iter_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .load     (w_cnt_load),
    .load_val (CNT_W'(WIDTH-1)),
    .en_dec   (w_cnt_dec),
    .zero     (w_cnt_zero),
    .out      (w_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_src_ready <= 1'b1;
      r_dst_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_src_ready <= 1'b1;
      r_dst_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (src_valid) begin
            r_rem       <= '0;
            r_quo       <= w_dvd_mag;
            r_dvs       <= w_dvs_mag;
            r_neg_q     <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r     <= w_dvd_neg;
            r_src_ready <= 1'b0;
            if (divisor == '0) begin
              r_state     <= DONE;
              r_dst_valid <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_state <= CALC;
              r_dbz   <= 1'b0;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (w_cnt_zero) begin
            r_state     <= DONE;
            r_dst_valid <= 1'b1;
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
          end
        end
        DONE: begin
          if (dst_ready) begin
            r_state     <= IDLE;
            r_dst_valid <= 1'b0;
            r_src_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_src_ready <= 1'b1;
          r_dst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign src_ready   = r_src_ready;
  assign dst_valid   = r_dst_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;
  assign dbg_count   = w_cnt;

endmodule
